// File: rtl/seq_result_bcd_converter.sv
// Iterative result selector and binary-to-BCD converter (shift-add-3, one bit per clock).
// Produces registered BCD digits, an overflow/saturation flag and a leading-zero mask.
module seq_result_bcd_converter #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4,
  parameter int unsigned N_SRC  = 2,
  parameter int unsigned SEL_W  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC*BIN_W-1:0]   src_bin,
  input  logic [SEL_W-1:0]         src_sel,
  input  logic                     is_res,
  input  logic                     start,
  output logic                     ready,
  output logic                     done,
  output logic [4*DIGITS-1:0]      result_bcd,
  output logic                     ovf,
  output logic [DIGITS-1:0]        lz_mask
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned ACC_W = BCD_W + 4;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [BIN_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [DIGITS-1:0]  lz_q, lz_d;

  logic [BIN_W-1:0]   sel_bin;
  logic [ACC_W-1:0]   adj;
  logic               ovf_c;
  logic [DIGITS-1:0]  lz_c;
  logic               lead;

  // Source mux; indices at or beyond N_SRC fall through to zero.
  always_comb begin
    sel_bin = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (src_sel == SEL_W'(k)) sel_bin = src_bin[k*BIN_W +: BIN_W];
    end
  end

  // Add-3 correction on every accumulator digit, guard digit included.
  always_comb begin
    adj = acc_q;
    for (int unsigned i = 0; i < DIGITS + 1; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // Final-digit decode: guard digit overflow and leading zeros scanned from the MSD.
  always_comb begin
    ovf_c = |acc_q[ACC_W-1 -: 4];
    lz_c  = '0;
    lead  = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (acc_q[4*i +: 4] != 4'd0) lead = 1'b0;
      lz_c[i] = lead;
    end
    if (ovf_c) lz_c = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      lz_q    <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      lz_q    <= lz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    lz_d    = lz_q;
    case (state_q)
      IDLE: begin
        if (start && ready_q) begin
          sh_d    = is_res ? sel_bin : '0;
          acc_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          ready_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, sh_d} = {adj, sh_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        ovf_d   = ovf_c;
        bcd_d   = ovf_c ? {DIGITS{4'h9}} : acc_q[BCD_W-1:0];
        lz_d    = lz_c;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign result_bcd = bcd_q;
  assign ovf        = ovf_q;
  assign lz_mask    = lz_q;

endmodule

// File: tb/tb_seq_result_bcd_converter.sv
// Self-checking bench: two configurations against a cycle-level behavioural model.
module tb_seq_result_bcd_converter;

  localparam int unsigned AB = 14, AD = 4, AN = 2, AS = 1;
  localparam int unsigned BB = 20, BD = 6, BN = 4, BS = 2;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;
  bit   b_fin  = 0;

  logic [AN*AB-1:0] a_src;
  logic [AS-1:0]    a_sel;
  logic             a_isr, a_start, a_ready, a_done, a_ovf;
  logic [4*AD-1:0]  a_bcd;
  logic [AD-1:0]    a_lz;

  logic [BN*BB-1:0] b_src;
  logic [BS-1:0]    b_sel;
  logic             b_isr, b_start, b_ready, b_done, b_ovf;
  logic [4*BD-1:0]  b_bcd;
  logic [BD-1:0]    b_lz;

  seq_result_bcd_converter #(.BIN_W(AB), .DIGITS(AD), .N_SRC(AN), .SEL_W(AS)) u_a (
    .clk(clk), .rst(rst), .src_bin(a_src), .src_sel(a_sel), .is_res(a_isr),
    .start(a_start), .ready(a_ready), .done(a_done), .result_bcd(a_bcd),
    .ovf(a_ovf), .lz_mask(a_lz));

  seq_result_bcd_converter #(.BIN_W(BB), .DIGITS(BD), .N_SRC(BN), .SEL_W(BS)) u_b (
    .clk(clk), .rst(rst), .src_bin(b_src), .src_sel(b_sel), .is_res(b_isr),
    .start(b_start), .ready(b_ready), .done(b_done), .result_bcd(b_bcd),
    .ovf(b_ovf), .lz_mask(b_lz));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs for value v: {lz[48:33], ovf[32], bcd[31:0]}.
  function automatic logic [63:0] model_conv(input longint unsigned v, input int digits);
    longint unsigned p, t;
    logic [63:0] r;
    r = '0;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    if (v >= p) begin
      r[32] = 1'b1;
      for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'h9;
    end else begin
      t = v;
      for (int i = 0; i < digits; i++) begin
        r[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
      p = 10;
      for (int i = 1; i < digits; i++) begin
        r[33+i] = (v < p);
        p = p * 10;
      end
    end
    return r;
  endfunction

  // Model A: fixed latency of BIN_W+1 cycles from accept to done.
  logic            am_ready, am_done, am_ovf;
  logic [4*AD-1:0] am_bcd;
  logic [AD-1:0]   am_lz;
  logic [63:0]     a_pend;
  int              a_timer;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      am_ready <= 1'b1; am_done <= 1'b0; am_ovf <= 1'b0; am_bcd <= '0;
      am_lz <= {{(AD-1){1'b1}}, 1'b0}; a_timer <= 0;
    end else begin
      am_done <= 1'b0;
      if (a_timer != 0) begin
        a_timer <= a_timer - 1;
        if (a_timer == 1) begin
          am_bcd <= a_pend[4*AD-1:0]; am_ovf <= a_pend[32]; am_lz <= a_pend[33 +: AD];
          am_done <= 1'b1; am_ready <= 1'b1;
        end
      end else if (a_start && am_ready) begin
        a_pend   <= model_conv((a_isr && int'(a_sel) < int'(AN)) ? a_src[a_sel*AB +: AB] : 0, AD);
        a_timer  <= AB + 1;
        am_ready <= 1'b0;
      end
    end
  end

  logic            bm_ready, bm_done, bm_ovf;
  logic [4*BD-1:0] bm_bcd;
  logic [BD-1:0]   bm_lz;
  logic [63:0]     b_pend;
  int              b_timer;
  int              b_ndone = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bm_ready <= 1'b1; bm_done <= 1'b0; bm_ovf <= 1'b0; bm_bcd <= '0;
      bm_lz <= {{(BD-1){1'b1}}, 1'b0}; b_timer <= 0;
    end else begin
      bm_done <= 1'b0;
      if (b_timer != 0) begin
        b_timer <= b_timer - 1;
        if (b_timer == 1) begin
          bm_bcd <= b_pend[4*BD-1:0]; bm_ovf <= b_pend[32]; bm_lz <= b_pend[33 +: BD];
          bm_done <= 1'b1; bm_ready <= 1'b1;
        end
      end else if (b_start && bm_ready) begin
        b_pend   <= model_conv((b_isr && int'(b_sel) < int'(BN)) ? b_src[b_sel*BB +: BB] : 0, BD);
        b_timer  <= BB + 1;
        bm_ready <= 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison, sampled just after the active edge.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("a_ready", a_ready, am_ready);
      chk("a_done",  a_done,  am_done);
      chk("a_bcd",   a_bcd,   am_bcd);
      chk("a_ovf",   a_ovf,   am_ovf);
      chk("a_lz",    a_lz,    am_lz);
      chk("b_ready", b_ready, bm_ready);
      chk("b_done",  b_done,  bm_done);
      chk("b_bcd",   b_bcd,   bm_bcd);
      chk("b_ovf",   b_ovf,   bm_ovf);
      chk("b_lz",    b_lz,    bm_lz);
      if (b_done) b_ndone++;
    end
  end

  task automatic a_conv(input int sel, input int val, input bit isr, input bit poke,
                        input logic [15:0] eb, input bit eo, input logic [3:0] el,
                        input string nm);
    int lat, nd;
    @(negedge clk);
    a_src[sel*AB +: AB] = AB'(val);
    a_sel = AS'(sel); a_isr = isr; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_src = ~a_src; a_sel = ~a_sel; a_isr = ~isr;
    lat = 0;
    while (!a_done && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (poke && lat == 5) a_start = 1'b1;
      if (poke && lat == 6) a_start = 1'b0;
    end
    chk({nm, "_latency"}, lat, AB + 1);
    chk({nm, "_bcd"}, a_bcd, eb);
    chk({nm, "_ovf"}, a_ovf, eo);
    chk({nm, "_lz"},  a_lz,  el);
    nd = 0;
    repeat (AB + 4) begin @(posedge clk); #1; if (a_done) nd++; end
    chk({nm, "_extra_done"}, nd, 0);
  endtask

  initial begin
    int nd, last, v;
    rst = 1'b1;
    a_src = '0; a_sel = '0; a_isr = 1'b0; a_start = 1'b0;
    chk_en = 1'b1;
    // Pin the reference model with hand-derived values.
    chk("model_1234",  model_conv(1234, 4),  64'h0000_0000_0000_1234);
    chk("model_7",     model_conv(7, 4),     64'h0000_001C_0000_0007);
    chk("model_0",     model_conv(0, 4),     64'h0000_001C_0000_0000);
    chk("model_9999",  model_conv(9999, 4),  64'h0000_0000_0000_9999);
    chk("model_10000", model_conv(10000, 4), 64'h0000_0001_0000_9999);
    repeat (2) @(negedge clk);
    chk("rst_ready", a_ready, 1'b1);
    chk("rst_bcd",   a_bcd,   16'h0000);
    chk("rst_lz",    a_lz,    4'b1110);
    chk("rst_done",  a_done,  1'b0);
    rst = 1'b0;

    a_conv(1, 1234,  1'b1, 1'b0, 16'h1234, 1'b0, 4'b0000, "t1234");
    a_conv(0, 7,     1'b1, 1'b0, 16'h0007, 1'b0, 4'b1110, "t7");
    a_conv(0, 0,     1'b1, 1'b0, 16'h0000, 1'b0, 4'b1110, "t0");
    a_conv(1, 9999,  1'b1, 1'b0, 16'h9999, 1'b0, 4'b0000, "t9999");
    a_conv(0, 10000, 1'b1, 1'b0, 16'h9999, 1'b1, 4'b0000, "t10000");
    a_conv(1, 16383, 1'b1, 1'b0, 16'h9999, 1'b1, 4'b0000, "t16383");
    a_conv(1, 4321,  1'b0, 1'b1, 16'h0000, 1'b0, 4'b1110, "tblank");
    a_conv(0, 56,    1'b1, 1'b1, 16'h0056, 1'b0, 4'b1100, "tpoke");

    // Reset in the middle of a conversion.
    @(negedge clk);
    a_src[AB +: AB] = AB'(4321); a_sel = 1'b1; a_isr = 1'b1; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready", a_ready, 1'b1);
    chk("midrst_bcd",   a_bcd,   16'h0000);
    chk("midrst_done",  a_done,  1'b0);
    chk("midrst_lz",    a_lz,    4'b1110);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (AB + 4) begin @(posedge clk); #1; if (a_done) nd++; end
    chk("midrst_no_done", nd, 0);
    a_conv(1, 805, 1'b1, 1'b0, 16'h0805, 1'b0, 4'b1000, "tafter_rst");

    // Back-to-back with start held high; sources change every cycle.
    last = -1;
    @(negedge clk);
    a_start = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      a_src = AN*AB'($urandom);
      a_sel = AS'($urandom_range(0, 1));
      a_isr = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      if (a_done) begin
        if (last >= 0) chk("b2b_period", c - last, AB + 2);
        last = c;
      end
    end
    @(negedge clk);
    a_start = 1'b0;

    // Randomized traffic with boundary-biased values.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      a_start = ($urandom_range(0, 2) == 0);
      a_sel   = AS'($urandom_range(0, 1));
      a_isr   = ($urandom_range(0, 4) != 0);
      a_src   = AN*AB'($urandom);
      case ($urandom_range(0, 5))
        0: v = 0;
        1: v = 9999;
        2: v = 10000;
        3: v = 16383;
        default: v = int'($urandom_range(0, 16383));
      endcase
      a_src[a_sel*AB +: AB] = AB'(v);
    end
    a_start = 1'b0;
    wait (b_fin);
    repeat (BB + 4) @(negedge clk);
    chk("b_saw_dones", (b_ndone > 40), 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Second configuration: wider sources, more digits, four sources.
  initial begin
    int v;
    b_src = '0; b_sel = '0; b_isr = 1'b0; b_start = 1'b0;
    @(negedge rst);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      b_start = ($urandom_range(0, 3) == 0) || (c > 2500 && c < 2700);
      for (int k = 0; k < int'(BN); k++) b_src[k*BB +: BB] = BB'($urandom);
      b_sel = BS'($urandom_range(0, 3));
      b_isr = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 5))
        0: v = 999999;
        1: v = 1000000;
        2: v = 1048575;
        3: v = 0;
        default: v = int'($urandom_range(0, 1048575));
      endcase
      b_src[b_sel*BB +: BB] = BB'(v);
    end
    b_start = 1'b0;
    b_fin = 1'b1;
  end

endmodule
